// File: rtl/core_array_pkg.sv
// Shared definitions for the core array feeder: lane state encoding,
// default widths and timing constants.
package core_array_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_FILL  = 2'd2,
      ST_HOLD  = 2'd3
   } lane_state_e;

   localparam int DATA_SIZE_DEF  = 8;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int SETUP_CYC_DEF  = 1;
   localparam int FILL_CYC_DEF   = 1;
   localparam int GAP_CYC_DEF    = 1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/feeder_lane.sv
// One feeder lane: word FIFO, IDLE/SETUP/FILL/HOLD strobe sequencer and
// its phase counter. The popped word stays on data_o until the next pop.
module feeder_lane
   import core_array_pkg::*;
#(
   parameter int DW        = DATA_SIZE_DEF,
   parameter int DEPTH     = FIFO_DEPTH_DEF,
   parameter int SETUP_CYC = SETUP_CYC_DEF,
   parameter int FILL_CYC  = FILL_CYC_DEF,
   parameter int GAP_CYC   = GAP_CYC_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [DW-1:0]            push_data_i,
   input  logic                     start_i,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     idle_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [DW-1:0]            data_o,
   output logic                     fill_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(max3(SETUP_CYC, FILL_CYC, GAP_CYC)) + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [DW-1:0] data_q;
   lane_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fill_q, fill_d;
   logic          pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LW'(DEPTH));
   assign idle_o  = (state_q == ST_IDLE);
   assign level_o = level_q;
   assign data_o  = data_q;
   assign fill_o  = fill_q;

   assign pop = idle_o & start_i & ~empty_o;

   // Storage array carries no reset so it maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (push_i) mem[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         data_q   <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            data_q   <= mem[rd_ptr_q];
         end
         case ({push_i, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
      end
   end

   // Counter is loaded with (cycles-1) on every state entry and counts down.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_SETUP;
               cnt_d   = CW'(SETUP_CYC - 1);
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_FILL;
               cnt_d   = CW'(FILL_CYC - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FILL: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = CW'(GAP_CYC - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      fill_d = (state_d == ST_FILL);
   end

endmodule

// File: rtl/core_array_feeder.sv
// Front end for the 2x2 core array: steers tagged input words into two
// lane feeders and optionally aligns their strobes.
module core_array_feeder
   import core_array_pkg::*;
#(
   parameter int data_size  = DATA_SIZE_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int SETUP_CYC  = SETUP_CYC_DEF,
   parameter int FILL_CYC   = FILL_CYC_DEF,
   parameter int GAP_CYC    = GAP_CYC_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [data_size-1:0]          s_data,
   input  logic                          s_lane,
   input  logic                          sync_en,
   output logic [data_size-1:0]          arr_data1,
   output logic                          arr_fill1,
   output logic [data_size-1:0]          arr_data2,
   output logic                          arr_fill2,
   output logic [$clog2(FIFO_DEPTH):0]   level1,
   output logic [$clog2(FIFO_DEPTH):0]   level2,
   output logic                          busy
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                 ready_en_q;
   logic [1:0]           lane_push, lane_start, lane_empty, lane_full, lane_idle, lane_fill;
   logic [data_size-1:0] lane_data  [2];
   logic [LW-1:0]        lane_level [2];
   logic                 sync_start;

   // Holds s_ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en_q <= 1'b0;
      else        ready_en_q <= 1'b1;
   end

   assign s_ready    = ready_en_q & ~(s_lane ? lane_full[1] : lane_full[0]);
   assign sync_start = (&(~lane_empty)) & (&lane_idle);

   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_push[gi]  = s_valid & s_ready & (s_lane == 1'(gi));
      assign lane_start[gi] = sync_en ? sync_start : ~lane_empty[gi];

      feeder_lane #(
         .DW        (data_size),
         .DEPTH     (FIFO_DEPTH),
         .SETUP_CYC (SETUP_CYC),
         .FILL_CYC  (FILL_CYC),
         .GAP_CYC   (GAP_CYC)
      ) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .push_i      (lane_push[gi]),
         .push_data_i (s_data),
         .start_i     (lane_start[gi]),
         .empty_o     (lane_empty[gi]),
         .full_o      (lane_full[gi]),
         .idle_o      (lane_idle[gi]),
         .level_o     (lane_level[gi]),
         .data_o      (lane_data[gi]),
         .fill_o      (lane_fill[gi])
      );
   end

   assign arr_data1 = lane_data[0];
   assign arr_fill1 = lane_fill[0];
   assign arr_data2 = lane_data[1];
   assign arr_fill2 = lane_fill[1];
   assign level1    = lane_level[0];
   assign level2    = lane_level[1];
   assign busy      = ~(&lane_empty) | ~(&lane_idle);

endmodule

// File: tb/tb_core_array_feeder.sv
// Directed bench for core_array_feeder: inputs change and outputs are
// sampled on the falling edge, DUT state advances on the rising edge.
module tb_core_array_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid, s_ready, s_lane, sync_en;
   logic [7:0] s_data;
   logic [7:0] arr_data1, arr_data2;
   logic       arr_fill1, arr_fill2, busy;
   logic [2:0] level1, level2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   core_array_feeder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_lane    (s_lane),
      .sync_en   (sync_en),
      .arr_data1 (arr_data1),
      .arr_fill1 (arr_fill1),
      .arr_data2 (arr_data2),
      .arr_fill2 (arr_fill2),
      .level1    (level1),
      .level2    (level2),
      .busy      (busy)
   );

   task automatic test_reset;
      rst_n = 1'b0; s_valid = 1'b0; s_lane = 1'b0; s_data = '0; sync_en = 1'b0;
      #12;
      n_checks++; if ({arr_fill1, arr_fill2, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_fill_busy: got %b expected 000", {arr_fill1, arr_fill2, busy}); end
      n_checks++; if ({arr_data1, arr_data2} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", {arr_data1, arr_data2}); end
      n_checks++; if ({level1, level2} !== 6'd0) begin n_fail++; $display("FAIL reset_levels: got %0d/%0d expected 0/0", level1, level2); end
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_clock: got %b expected 0", s_ready); end
      @(negedge clk);
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_clock: got %b expected 1", s_ready); end
      $display("test_reset done");
   endtask

   task automatic test_single;
      s_valid = 1'b1; s_lane = 1'b0; s_data = 8'd128;
      @(negedge clk); s_valid = 1'b0;                       // edge t
      n_checks++; if (level1 !== 3'd1 || arr_data1 !== 8'd0) begin n_fail++; $display("FAIL single_t: level %0d data %0d expected 1/0", level1, arr_data1); end
      @(negedge clk);                                       // t+1
      n_checks++; if (arr_data1 !== 8'd128 || arr_fill1 !== 1'b0) begin n_fail++; $display("FAIL single_t1: data %0d fill %b expected 128/0", arr_data1, arr_fill1); end
      @(negedge clk);                                       // t+2
      n_checks++; if (arr_fill1 !== 1'b1) begin n_fail++; $display("FAIL single_fill: got %b expected 1", arr_fill1); end
      @(negedge clk);                                       // t+3
      n_checks++; if (arr_fill1 !== 1'b0 || arr_data1 !== 8'd128) begin n_fail++; $display("FAIL single_hold: fill %b data %0d expected 0/128", arr_fill1, arr_data1); end
      n_checks++; if (arr_fill2 !== 1'b0 || arr_data2 !== 8'd0 || level2 !== 3'd0) begin n_fail++; $display("FAIL single_lane2_quiet: fill %b data %0d level %0d expected 0/0/0", arr_fill2, arr_data2, level2); end
      @(negedge clk);                                       // t+4
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b expected 0", busy); end
      $display("test_single done");
   endtask

   task automatic test_sync;
      sync_en = 1'b1;
      s_valid = 1'b1; s_lane = 1'b0; s_data = 8'd105;
      @(negedge clk); s_valid = 1'b0;                       // t
      @(negedge clk); @(negedge clk);                       // t+2
      s_valid = 1'b1; s_lane = 1'b1; s_data = 8'd89;
      @(negedge clk); s_valid = 1'b0;                       // t+3
      n_checks++; if (arr_data1 !== 8'd128 || level1 !== 3'd1 || level2 !== 3'd1) begin n_fail++; $display("FAIL sync_wait: data1 %0d levels %0d/%0d expected 128 1/1", arr_data1, level1, level2); end
      @(negedge clk);                                       // t+4
      n_checks++; if (arr_data1 !== 8'd105 || arr_data2 !== 8'd89) begin n_fail++; $display("FAIL sync_pop: data %0d/%0d expected 105/89", arr_data1, arr_data2); end
      @(negedge clk);                                       // t+5
      n_checks++; if ({arr_fill1, arr_fill2} !== 2'b11) begin n_fail++; $display("FAIL sync_fill: got %b expected 11", {arr_fill1, arr_fill2}); end
      @(negedge clk);
      n_checks++; if ({arr_fill1, arr_fill2} !== 2'b00) begin n_fail++; $display("FAIL sync_hold: got %b expected 00", {arr_fill1, arr_fill2}); end
      @(negedge clk);
      sync_en = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sync_idle: busy %b expected 0", busy); end
      $display("test_sync done");
   endtask

   task automatic test_independent;
      s_valid = 1'b1; s_lane = 1'b1; s_data = 8'd234;
      @(negedge clk);                                       // t
      s_lane = 1'b0; s_data = 8'd128;
      @(negedge clk); s_valid = 1'b0;                       // t+1
      n_checks++; if (arr_fill2 !== 1'b0 || arr_data2 !== 8'd234) begin n_fail++; $display("FAIL indep_t1: fill2 %b data2 %0d expected 0/234", arr_fill2, arr_data2); end
      @(negedge clk);                                       // t+2
      n_checks++; if ({arr_fill1, arr_fill2} !== 2'b01 || arr_data1 !== 8'd128) begin n_fail++; $display("FAIL indep_t2: fills %b data1 %0d expected 01/128", {arr_fill1, arr_fill2}, arr_data1); end
      @(negedge clk);                                       // t+3
      n_checks++; if ({arr_fill1, arr_fill2} !== 2'b10) begin n_fail++; $display("FAIL indep_t3: fills %b expected 10", {arr_fill1, arr_fill2}); end
      @(negedge clk); @(negedge clk);                       // t+5
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL indep_idle: busy %b expected 0", busy); end
      $display("test_independent done");
   endtask

   task automatic test_back_to_back;
      sync_en = 1'b1;                                       // lane0 empty keeps lane2 from popping
      s_valid = 1'b1; s_lane = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_data = 8'(i);
         @(negedge clk);
      end
      n_checks++; if (level2 !== 3'd4 || s_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: level %0d ready %b expected 4/0", level2, s_ready); end
      s_data = 8'd5; sync_en = 1'b0;
      @(negedge clk);                                       // edge e: pop word 1, no push
      n_checks++; if (s_ready !== 1'b1 || level2 !== 3'd3 || arr_data2 !== 8'd1) begin n_fail++; $display("FAIL b2b_pop: ready %b level %0d data %0d expected 1/3/1", s_ready, level2, arr_data2); end
      @(negedge clk); s_valid = 1'b0;                       // e+1: word 5 accepted
      n_checks++; if (arr_fill2 !== 1'b1 || arr_data2 !== 8'd1 || level2 !== 3'd4) begin n_fail++; $display("FAIL b2b_first: fill %b data %0d level %0d expected 1/1/4", arr_fill2, arr_data2, level2); end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         n_checks++; if (arr_fill2 !== ((k % 4) == 0)) begin n_fail++; $display("FAIL b2b_fill k=%0d: got %b expected %b", k, arr_fill2, ((k % 4) == 0)); end
         if ((k % 4) == 0) begin
            n_checks++; if (arr_data2 !== 8'(1 + k / 4)) begin n_fail++; $display("FAIL b2b_order k=%0d: got %0d expected %0d", k, arr_data2, 1 + k / 4); end
         end
      end
      @(negedge clk); @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b expected 0", busy); end
      $display("test_back_to_back done");
   endtask

   task automatic test_push_pop_same;
      sync_en = 1'b1;
      s_valid = 1'b1; s_lane = 1'b0;
      for (int i = 11; i <= 13; i++) begin
         s_data = 8'(i);
         @(negedge clk);
      end
      n_checks++; if (level1 !== 3'd3) begin n_fail++; $display("FAIL pp_pre: level %0d expected 3", level1); end
      s_data = 8'd14; sync_en = 1'b0;
      @(negedge clk); s_valid = 1'b0;                       // edge p: push 14 and pop 11
      n_checks++; if (level1 !== 3'd3 || s_ready !== 1'b1 || arr_data1 !== 8'd11) begin n_fail++; $display("FAIL pp_same: level %0d ready %b data %0d expected 3/1/11", level1, s_ready, arr_data1); end
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         n_checks++; if (arr_fill1 !== ((k % 4) == 1)) begin n_fail++; $display("FAIL pp_fill k=%0d: got %b expected %b", k, arr_fill1, ((k % 4) == 1)); end
         if ((k % 4) == 1) begin
            n_checks++; if (arr_data1 !== 8'(11 + k / 4)) begin n_fail++; $display("FAIL pp_order k=%0d: got %0d expected %0d", k, arr_data1, 11 + k / 4); end
         end
      end
      @(negedge clk); @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pp_idle: busy %b expected 0", busy); end
      $display("test_push_pop_same done");
   endtask

   task automatic test_reset_mid;
      sync_en = 1'b1;
      s_valid = 1'b1; s_lane = 1'b0;
      for (int i = 21; i <= 24; i++) begin
         s_data = 8'(i);
         @(negedge clk);
      end
      s_valid = 1'b0; sync_en = 1'b0;
      @(negedge clk);                                       // pop 21
      @(negedge clk);                                       // FILL
      n_checks++; if (arr_fill1 !== 1'b1 || level1 !== 3'd3) begin n_fail++; $display("FAIL rmid_pre: fill %b level %0d expected 1/3", arr_fill1, level1); end
      #2 rst_n = 1'b0; #1;
      n_checks++; if (arr_fill1 !== 1'b0 || level1 !== 3'd0 || arr_data1 !== 8'd0) begin n_fail++; $display("FAIL rmid_async: fill %b level %0d data %0d expected 0/0/0", arr_fill1, level1, arr_data1); end
      n_checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_ready: busy %b ready %b expected 0/0", busy, s_ready); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_checks++; if (arr_fill1 !== 1'b0 || level1 !== 3'd0) begin n_fail++; $display("FAIL rmid_quiet k=%0d: fill %b level %0d expected 0/0", k, arr_fill1, level1); end
      end
      s_valid = 1'b1; s_lane = 1'b0; s_data = 8'd77;
      @(negedge clk); s_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      n_checks++; if (arr_fill1 !== 1'b1 || arr_data1 !== 8'd77) begin n_fail++; $display("FAIL rmid_new: fill %b data %0d expected 1/77", arr_fill1, arr_data1); end
      @(negedge clk); @(negedge clk);
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_sync();
      test_independent();
      test_back_to_back();
      test_push_pop_same();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
